// File: rtl/shift_seq_unit_if.sv
// Operand/result handshake bundle for shift_seq_unit.
// master = producer/consumer side, slave = the shift unit.
interface shift_seq_unit_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in;
   logic [1:0]       shift;
   logic [AMT_W-1:0] amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;

   modport master (
      output in_valid, in, shift, amt, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in, shift, amt, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/shift_seq_unit.sv
// Iterative shifter: one bit position per clock for LSL/LSR/ASR (opcodes 01/10/11).
// Optional macro SHIFT_SEQ_ROR_EN turns opcode 00 from pass-through into rotate-right.
module shift_seq_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   shift_seq_unit_if.slave  bus,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             pass_op;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] op);
      logic [WIDTH-1:0] r;
      case (op)
         2'b01:   r = {d[WIDTH-2:0], 1'b0};
         2'b10:   r = {1'b0, d[WIDTH-1:1]};
         2'b11:   r = {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROR_EN
         default: r = {d[0], d[WIDTH-1:1]};
`else
         default: r = d;
`endif
      endcase
      return r;
   endfunction

`ifdef SHIFT_SEQ_ROR_EN
   assign pass_op = 1'b0;
`else
   assign pass_op = (bus.shift == 2'b00);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      op_d          = op_q;
      cnt_d         = cnt_q;
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.out       = data_q;
      busy          = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d = bus.in;
               op_d   = bus.shift;
               cnt_d  = bus.amt;
               if (bus.amt == '0 || pass_op) state_d = DONE;
               else                          state_d = SHIFT;
            end
         end
         SHIFT: begin
            data_d = step(data_q, op_q);
            if (cnt_q != '0) cnt_d = cnt_q - AMT_W'(1);
            // <=1 rather than ==1 so a zero count can never strand the FSM here
            if (cnt_q <= AMT_W'(1)) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: arithmetic reference model plus directed vectors.
module tb_shift_seq_unit;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned AMT_W = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   shift_seq_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

   shift_seq_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

`ifdef SHIFT_SEQ_ROR_EN
   localparam bit ROR = 1'b1;
`else
   localparam bit ROR = 1'b0;
`endif

   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op, input int a);
      case (op)
         2'b01: return d << a;
         2'b10: return d >> a;
         2'b11: return 16'($signed(d) >>> a);
         default: begin
            if (ROR && a != 0) return (d >> a) | (d << (16 - a));
            return d;
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input int a);
      if (a == 0 || (op == 2'b00 && !ROR)) return 1;
      return a + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: 0 = waiting for work, 1 = result in progress, 2 = result offered
   int          m_ph   = 0;
   int          m_left = 0;
   logic [15:0] m_res  = '0;
   bit          m_zero = 1'b1;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ph = 0; m_res = '0; m_zero = 1'b1; m_left = 0;
      end else begin
         case (m_ph)
            0: if (bus.in_valid) begin
                  m_res  = ref_shift(bus.in, bus.shift, int'(bus.amt));
                  m_left = ref_lat(bus.shift, int'(bus.amt)) - 1;
                  m_zero = 1'b0;
                  m_ph   = (m_left == 0) ? 2 : 1;
               end
            1: begin
                  m_left--;
                  if (m_left == 0) m_ph = 2;
               end
            default: if (bus.out_ready) m_ph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("m_in_ready", 32'(bus.in_ready), 32'(m_ph == 0));
         chk("m_out_valid", 32'(bus.out_valid), 32'(m_ph == 2));
         chk("m_busy", 32'(busy), 32'(m_ph != 0));
         if (m_ph == 2) chk("m_out", 32'(bus.out), 32'(m_res));
         if (m_ph == 0 && m_zero) chk("m_out_reset", 32'(bus.out), 32'h0);
      end
   end

   task automatic run_op(input string name, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] a, input logic [15:0] expv, input int explat,
                         input bit hold);
      int cyc;
      logic [15:0] held;
      @(posedge clk); #1;
      bus.in = d; bus.shift = op; bus.amt = a; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in = ~d; bus.shift = ~op; bus.amt = ~a;
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         chk({name, "_in_ready_low"}, 32'(bus.in_ready), 32'h0);
         @(posedge clk); #1;
         cyc++;
      end
      chk({name, "_latency"}, 32'(cyc), 32'(explat));
      chk({name, "_out"}, 32'(bus.out), 32'(expv));
      if (hold) begin
         held = bus.out;
         repeat (3) begin
            bus.in_valid = 1'b1; bus.in = 16'h5A5A; bus.shift = 2'b01; bus.amt = 4'd3;
            @(posedge clk); #1;
            chk({name, "_hold_out"}, 32'(bus.out), 32'(held));
            chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'h1);
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({name, "_idle_ready"}, 32'(bus.in_ready), 32'h1);
      chk({name, "_idle_valid"}, 32'(bus.out_valid), 32'h0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in = '0; bus.shift = '0; bus.amt = '0; bus.out_ready = 1'b0;
      #2;
      chk("reset_out", 32'(bus.out), 32'h0);
      chk("reset_valid", 32'(bus.out_valid), 32'h0);
      chk("reset_ready", 32'(bus.in_ready), 32'h1);
      chk("reset_busy", 32'(busy), 32'h0);
      #10 reset_n = 1'b1;

      run_op("lsl1", 16'hF0CF, 2'b01, 4'd1, 16'hE19E, 2, 1'b0);
      run_op("lsr1", 16'hF0CF, 2'b10, 4'd1, 16'h7867, 2, 1'b0);
      run_op("asr1", 16'hF0CF, 2'b11, 4'd1, 16'hF867, 2, 1'b0);
      run_op("lsr15", 16'hFFFF, 2'b10, 4'd15, 16'h0001, 16, 1'b0);
      run_op("asr4", 16'h8000, 2'b11, 4'd4, 16'hF800, 5, 1'b0);
      run_op("lsl0", 16'h1234, 2'b01, 4'd0, 16'h1234, 1, 1'b0);
`ifdef SHIFT_SEQ_ROR_EN
      run_op("ror1", 16'h0001, 2'b00, 4'd1, 16'h8000, 2, 1'b0);
      run_op("ror15", 16'h0001, 2'b00, 4'd15, 16'h0002, 16, 1'b0);
      run_op("ror0", 16'h1234, 2'b00, 4'd0, 16'h1234, 1, 1'b0);
`else
      run_op("pass7", 16'h1234, 2'b00, 4'd7, 16'h1234, 1, 1'b0);
`endif
      run_op("backpressure", 16'hABCD, 2'b10, 4'd2, 16'h2AF3, 3, 1'b1);

      // Reset asserted mid-shift after three of eight positions
      @(posedge clk); #1;
      bus.in = 16'h00FF; bus.shift = 2'b01; bus.amt = 4'd8; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_out", 32'(bus.out), 32'h0);
      chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk); #3 reset_n = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         chk("post_rst_no_valid", 32'(bus.out_valid), 32'h0);
      end
      run_op("post_rst_lsl8", 16'h00FF, 2'b01, 4'd8, 16'hFF00, 9, 1'b0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
